// File: rtl/dac_sample_packer.sv
// dac_sample_packer
// Buffers four-sample input words in a small FIFO and streams one word per
// cycle onto four registered DAC lanes (s0 earliest). An IDLE/FILL/RUN
// controller waits for a start level before streaming, drops back to FILL on
// underflow, and marks the first word of each frame.
// Optional build macro DAC_PACKER_RAMP_EN adds input test_ramp, which
// replaces the popped data with a counting ramp while streaming.
module dac_sample_packer #(
    parameter int DATA_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int START_LEVEL = 4,
    parameter int FRAME_LEN   = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_CODE = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [4*DATA_WIDTH-1:0]       s_data,
`ifdef DAC_PACKER_RAMP_EN
    input  logic                          test_ramp,
`endif
    output logic [DATA_WIDTH-1:0]         data_s0,
    output logic [DATA_WIDTH-1:0]         data_s1,
    output logic [DATA_WIDTH-1:0]         data_s2,
    output logic [DATA_WIDTH-1:0]         data_s3,
    output logic                          frame_start,
    output logic                          running,
    output logic                          underflow,
    output logic [15:0]                   underflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int WW  = 4 * DATA_WIDTH;
    localparam int FCW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [WW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]         r_wr_ptr;
    logic [AW:0]         r_rd_ptr;
    logic [WW-1:0]       r_lanes;
    logic                r_frame_start;
    logic                r_running;
    logic                r_underflow;
    logic [15:0]         r_underflow_count;
    logic [FCW-1:0]      r_frame_cnt;

    logic [LW-1:0]       w_level;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_run_entry;
    logic [WW-1:0]       w_idle_word;
    logic [WW-1:0]       w_fifo_word;
    logic [WW-1:0]       w_lane_src;
    logic [DATA_WIDTH-1:0] w_lane [4];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign s_ready     = (w_level < LW'(FIFO_DEPTH)) && (r_state != ST_IDLE);
    assign w_push      = s_valid && s_ready;
    // Pop only what was present at cycle start; a same-cycle push never falls through.
    assign w_pop       = enable && (r_state == ST_RUN) && (w_level != '0);
    assign w_flush     = !enable || (r_state == ST_IDLE);
    assign w_run_entry = enable && (r_state == ST_FILL) && (w_level >= LW'(START_LEVEL));
    assign w_fifo_word = r_mem[r_rd_ptr[AW-1:0]];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_idle_word[gi*DATA_WIDTH +: DATA_WIDTH] = IDLE_CODE;
            assign w_lane[gi] = r_lanes[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

`ifdef DAC_PACKER_RAMP_EN
    logic [DATA_WIDTH-1:0] r_ramp;
    logic [WW-1:0]         w_ramp_word;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ramp
            assign w_ramp_word[gi*DATA_WIDTH +: DATA_WIDTH] = r_ramp + DATA_WIDTH'(gi);
        end
    endgenerate

    // Ramp base restarts at zero on each RUN entry and advances by one word per pop.
    always_ff @(posedge clk) begin
        if (rst || w_run_entry) begin
            r_ramp <= '0;
        end else if (w_pop) begin
            r_ramp <= r_ramp + DATA_WIDTH'(4);
        end
    end

    assign w_lane_src = test_ramp ? w_ramp_word : w_fifo_word;
`else
    assign w_lane_src = w_fifo_word;
`endif

    // FIFO storage write port; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= s_data;
        end
    end

    // FIFO pointers: cleared whenever idle or disabled, otherwise advanced by push/pop.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Stream controller with registered lanes, frame marker and underflow tracking.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state           <= ST_IDLE;
            r_lanes           <= w_idle_word;
            r_frame_start     <= 1'b0;
            r_running         <= 1'b0;
            r_underflow       <= 1'b0;
            r_underflow_count <= '0;
            r_frame_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lanes       <= w_idle_word;
                    r_frame_start <= 1'b0;
                    r_running     <= 1'b0;
                    r_frame_cnt   <= '0;
                    r_state       <= ST_FILL;
                end
                ST_FILL: begin
                    r_lanes       <= w_idle_word;
                    r_frame_start <= 1'b0;
                    r_running     <= 1'b0;
                    if (w_run_entry) begin
                        r_frame_cnt <= '0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pop) begin
                        r_lanes       <= w_lane_src;
                        r_running     <= 1'b1;
                        r_frame_start <= (r_frame_cnt == '0);
                        if (r_frame_cnt == FCW'(FRAME_LEN - 1)) begin
                            r_frame_cnt <= '0;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FCW'(1);
                        end
                    end else begin
                        // Starved: show one idle word and go back to refilling.
                        r_lanes       <= w_idle_word;
                        r_running     <= 1'b0;
                        r_frame_start <= 1'b0;
                        r_underflow   <= 1'b1;
                        if (r_underflow_count != 16'hFFFF) begin
                            r_underflow_count <= r_underflow_count + 16'd1;
                        end
                        r_state       <= ST_FILL;
                    end
                end
                default: begin
                    r_lanes       <= w_idle_word;
                    r_frame_start <= 1'b0;
                    r_running     <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_s0         = w_lane[0];
    assign data_s1         = w_lane[1];
    assign data_s2         = w_lane[2];
    assign data_s3         = w_lane[3];
    assign frame_start     = r_frame_start;
    assign running         = r_running;
    assign underflow       = r_underflow;
    assign underflow_count = r_underflow_count;
    assign fifo_level      = w_level;

endmodule

// File: doc/dac_sample_packer.md
DAC_SAMPLE_PACKER -- requirements
Module: dac_sample_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 17: bits per sample lane.
REQ-002 Parameter FIFO_DEPTH, default 8: words buffered; power of two, range 4..64.
REQ-003 Parameter START_LEVEL, default 4: fill level required before streaming starts; range 1..FIFO_DEPTH.
REQ-004 Parameter FRAME_LEN, default 16: output words per frame marker; range 2..65536.
REQ-005 Parameter IDLE_CODE, default 0: DATA_WIDTH-bit value driven on every lane when not streaming.
REQ-006 Port clk  in  1  sole clock (serializer divided-clock domain); all logic on rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port enable  in  1  high = stream requested; low = flush and idle.
REQ-009 Port s_valid  in  1  input word valid.
REQ-010 Port s_ready  out  1  input word accepted when s_valid and s_ready are both high.
REQ-011 Port s_data  in  4*DATA_WIDTH  four samples; bits [DATA_WIDTH-1:0] are the earliest in time.
REQ-012 Ports data_s0, data_s1, data_s2, data_s3  out  DATA_WIDTH each  registered lanes to the serializer; s0 earliest.
REQ-013 Port frame_start  out  1  one-cycle marker aligned with a frame's first output word.
REQ-014 Port running  out  1  high while in RUN.
REQ-015 Port underflow  out  1  sticky underflow flag.
REQ-016 Port underflow_count  out  16  count of underflow events; saturates at 16'hFFFF.
REQ-017 Port fifo_level  out  clog2(FIFO_DEPTH)+1  current number of words held.

Function
REQ-018 States: IDLE, FILL, RUN; a 2-bit registered state.
REQ-019 IDLE: FIFO flushed (level 0); lanes = IDLE_CODE; enable high -> FILL on the next cycle.
REQ-020 FILL: lanes = IDLE_CODE; transition to RUN on the cycle after fifo_level >= START_LEVEL.
REQ-021 RUN: pop one word per cycle; the popped word appears on data_s0..s3 exactly one cycle after the pop.
REQ-022 RUN with FIFO empty at cycle start: no pop; lanes = IDLE_CODE the next cycle; underflow set; underflow_count +1 (saturating); state -> FILL.
REQ-023 enable low in any state: state -> IDLE on the next cycle; FIFO flushed that cycle; underflow and underflow_count cleared.
REQ-024 Push rule: s_ready = (fifo_level < FIFO_DEPTH) and state != IDLE.
REQ-025 A push and a pop in the same cycle leave the level unchanged.
REQ-026 Pop only reads words present at cycle start; there is no fall-through of a same-cycle push into an empty FIFO.
REQ-027 Read and write pointers wrap modulo FIFO_DEPTH; level is computed from the pointers with one extra MSB.
REQ-028 Frame counter resets to 0 on entry to RUN and counts output words shown.
REQ-029 frame_start is high on the first valid word after entering RUN and on every FRAME_LEN-th word thereafter.
REQ-030 frame_start is never high on IDLE_CODE cycles.
REQ-031 running is high for exactly the cycles in which the lanes carry popped data.

Reset
REQ-032 On rst: state IDLE, pointers 0, lanes IDLE_CODE, frame_start 0, running 0, underflow 0, underflow_count 0, s_ready 0.
REQ-033 rst asserted mid-stream discards buffered words; the first output after release is IDLE_CODE.

Configuration
REQ-034 Macro DAC_PACKER_RAMP_EN compiles in input port test_ramp (1 bit).
REQ-035 With the macro defined and test_ramp high in RUN, lanes carry ramp values r, r+1, r+2, r+3 (modulo 2^DATA_WIDTH); r advances by 4 per cycle and starts at 0 on RUN entry.
REQ-036 In ramp mode the FIFO still pops, underflow still applies, and frame_start is unchanged.
REQ-037 Without the macro there is no test_ramp port and no ramp logic.

Verification
REQ-038 Reset release, enable=1, push words 1..4 back-to-back -> RUN entered; data_s0 shows 1,2,3,4 on consecutive cycles starting the cycle after the RUN pop; frame_start high with word 1.
REQ-039 Push 8 words with enable=1 and START_LEVEL=8 -> s_ready low at level 8; a 9th s_valid is not accepted.
REQ-040 Starve the FIFO in RUN -> one IDLE_CODE cycle; underflow=1; underflow_count=1; state FILL; after 4 new words, RUN resumes with frame_start on its first word.
REQ-041 Continuous feed, FRAME_LEN=16 -> frame_start on words 1, 17, 33; simultaneous push and pop holds level constant.
REQ-042 Drop enable mid-RUN with 5 words buffered -> next cycle IDLE, fifo_level=0, lanes IDLE_CODE, counters 0.
REQ-043 With DAC_PACKER_RAMP_EN defined and test_ramp=1, DATA_WIDTH=17 -> the first RUN word is 0,1,2,3 and the next is 4,5,6,7; values wrap from 131071 to 0.
